// File: rtl/smac_pkg.sv
// Shared definitions for the sub-word MAC datapath.
// The MAC lane array, the operand feeder and the result drain all use it.
// Packed lane layout: L0=[7:0], L1=[15:8], L2=[31:16], L3=[63:32].
package smac_pkg;

  localparam int LANES = 4;

  localparam int L0_LSB = 0;
  localparam int L0_MSB = 7;
  localparam int L1_LSB = 8;
  localparam int L1_MSB = 15;
  localparam int L2_LSB = 16;
  localparam int L2_MSB = 31;
  localparam int L3_LSB = 32;
  localparam int L3_MSB = 63;

  // A chained result occupies the whole word. It is reported as one beat
  // tagged with the top lane.
  localparam logic [LANES-1:0] CHAIN_MASK = 4'b1000;

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } smac_state_t;

endpackage

// File: rtl/smac_lane_extract.sv
// Combinational lane selection for the result drain.
// Ports:
//   word     - captured packed result word
//   mask     - remaining lane mask
//   lane     - index of the lowest set bit of mask (0 when mask is empty)
//   one_left - mask has exactly one bit set
//   value    - lane `lane` of word, sign- or zero-extended to 64 bits
module smac_lane_extract
  import smac_pkg::*;
#(
  parameter int SIGN_EXTEND = 1
) (
  input  logic [63:0]      word,
  input  logic [LANES-1:0] mask,
  output logic [1:0]       lane,
  output logic             one_left,
  output logic [63:0]      value
);

  localparam logic SX = (SIGN_EXTEND != 0);

  // Walk from the top lane down so that the lowest set bit wins.
  always_comb begin
    lane = 2'd0;
    for (int i = LANES - 1; i >= 0; i--) begin
      if (mask[i]) lane = 2'(i);
    end
  end

  assign one_left = (mask != '0) && ((mask & (mask - 4'd1)) == '0);

  always_comb begin
    value = '0;
    case (lane)
      2'd0: value = {{56{SX & word[L0_MSB]}}, word[L0_MSB:L0_LSB]};
      2'd1: value = {{56{SX & word[L1_MSB]}}, word[L1_MSB:L1_LSB]};
      2'd2: value = {{48{SX & word[L2_MSB]}}, word[L2_MSB:L2_LSB]};
      default: value = {{32{SX & word[L3_MSB]}}, word[L3_MSB:L3_LSB]};
    endcase
  end

endmodule

// File: rtl/smac_result_drain.sv
// Result drain: takes one packed MAC result word and sends each enabled
// lane downstream as a separate 64-bit beat. A chained word goes out as
// one full-width beat.
// Ports:
//   clk, sclr                     - clock, async active-high reset
//   res_valid/res_ready           - packed word handshake
//   res_data, select_precision    - word and lane enable mask
//   active_chain                  - word is one chained full-width result
//   out_valid/out_ready           - beat handshake
//   out_data, out_lane, out_last  - beat payload, lane index, final beat
//   beat_cnt                      - beats accepted downstream (wraps)
//   drop_cnt                      - empty words dropped (saturates)
//
// state | meaning
// IDLE  | waiting for a word, res_ready high
// EMIT  | presenting the beats of the captured word, lowest lane first
module smac_result_drain
  import smac_pkg::*;
#(
  parameter int SIGN_EXTEND = 1,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             sclr,
  input  logic             res_valid,
  output logic             res_ready,
  input  logic [63:0]      res_data,
  input  logic [3:0]       select_precision,
  input  logic             active_chain,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [63:0]      out_data,
  output logic [1:0]       out_lane,
  output logic             out_last,
  output logic [CNT_W-1:0] beat_cnt,
  output logic [CNT_W-1:0] drop_cnt
);

  smac_state_t      state_q, state_d;
  logic [63:0]      word_q;
  logic [LANES-1:0] mask_q;
  logic             chain_q;

  logic [LANES-1:0] in_mask;
  logic [1:0]       cur_lane;
  logic             one_left;
  logic [63:0]      lane_value;
  logic             word_acc;
  logic             beat_acc;

  assign in_mask = active_chain ? CHAIN_MASK : select_precision;

  smac_lane_extract #(
    .SIGN_EXTEND(SIGN_EXTEND)
  ) u_extract (
    .word    (word_q),
    .mask    (mask_q),
    .lane    (cur_lane),
    .one_left(one_left),
    .value   (lane_value)
  );

  always_ff @(posedge clk or posedge sclr) begin
    if (sclr) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // A new word may load in the cycle its predecessor's last beat leaves.
  // This gives a combinational out_ready -> res_ready path.
  always_comb begin
    state_d   = state_q;
    res_ready = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      IDLE: begin
        res_ready = 1'b1;
        if (res_valid && in_mask != '0) state_d = EMIT;
      end
      EMIT: begin
        out_valid = 1'b1;
        if (out_ready && one_left) begin
          res_ready = 1'b1;
          state_d   = (res_valid && in_mask != '0) ? EMIT : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (sclr) res_ready = 1'b0;
  end

  assign word_acc = res_valid & res_ready;
  assign beat_acc = out_valid & out_ready;

  assign out_data = out_valid ? (chain_q ? word_q : lane_value) : '0;
  assign out_lane = out_valid ? cur_lane : 2'd0;
  assign out_last = out_valid & one_left;

  always_ff @(posedge clk or posedge sclr) begin
    if (sclr) begin
      word_q   <= '0;
      mask_q   <= '0;
      chain_q  <= 1'b0;
      beat_cnt <= '0;
      drop_cnt <= '0;
    end else begin
      if (word_acc) begin
        word_q  <= res_data;
        mask_q  <= in_mask;
        chain_q <= active_chain;
        if (in_mask == '0 && drop_cnt != '1) drop_cnt <= drop_cnt + CNT_W'(1);
      end else if (beat_acc) begin
        mask_q <= mask_q & ~(4'b0001 << cur_lane);
      end
      if (beat_acc) beat_cnt <= beat_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_smac_result_drain.sv
module tb_smac_result_drain;

  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             sclr;
  logic             res_valid;
  logic             res_ready;
  logic [63:0]      res_data;
  logic [3:0]       select_precision;
  logic             active_chain;
  logic             out_valid;
  logic             out_ready;
  logic [63:0]      out_data;
  logic [1:0]       out_lane;
  logic             out_last;
  logic [CNT_W-1:0] beat_cnt;
  logic [CNT_W-1:0] drop_cnt;

  smac_result_drain #(.SIGN_EXTEND(1), .CNT_W(CNT_W)) dut (
    .clk             (clk),
    .sclr            (sclr),
    .res_valid       (res_valid),
    .res_ready       (res_ready),
    .res_data        (res_data),
    .select_precision(select_precision),
    .active_chain    (active_chain),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_data        (out_data),
    .out_lane        (out_lane),
    .out_last        (out_last),
    .beat_cnt        (beat_cnt),
    .drop_cnt        (drop_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [63:0] d;
    logic [1:0]  l;
    logic        last;
  } beat_t;

  beat_t exp_q[$];
  int    n_cmp = 0;
  int    n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input logic [63:0] d, input logic [1:0] l, input logic last);
    beat_t b;
    b.d = d; b.l = l; b.last = last;
    exp_q.push_back(b);
  endtask

  // Monitor: pops one expectation per accepted beat, and checks that a
  // stalled beat is unchanged when next seen.
  beat_t held;
  logic  stall_pend = 1'b0;
  initial begin
    beat_t e;
    forever begin
      @(negedge clk);
      if (out_valid && stall_pend) begin
        chk("stall_data", out_data, held.d);
        chk("stall_lane", 64'(out_lane), 64'(held.l));
        chk("stall_last", 64'(out_last), 64'(held.last));
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_beat_lane", 64'(out_lane), 64'hFFFF);
        end else begin
          e = exp_q.pop_front();
          chk("beat_data", out_data, e.d);
          chk("beat_lane", 64'(out_lane), 64'(e.l));
          chk("beat_last", 64'(out_last), 64'(e.last));
        end
      end
      stall_pend = out_valid && !out_ready;
      held.d = out_data; held.l = out_lane; held.last = out_last;
    end
  end

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send_word(input logic [63:0] d, input logic [3:0] m, input logic c);
    int n = 0;
    res_valid = 1'b1; res_data = d; select_precision = m; active_chain = c;
    @(negedge clk);
    while (!res_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!res_ready) chk("send_timeout", 64'(res_ready), 64'd1);
    @(posedge clk); #1;
    res_valid = 1'b0; res_data = 64'hDEAD_BEEF_DEAD_BEEF;
    select_precision = 4'hF; active_chain = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    @(negedge clk);
    while ((exp_q.size() != 0 || out_valid) && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("drain_queue", 64'(exp_q.size()), 64'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    sclr = 1'b1; res_valid = 1'b0; res_data = '0; select_precision = '0;
    active_chain = 1'b0; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_res_ready", 64'(res_ready), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_data", out_data, 64'd0);
    chk("rst_beat_cnt", 64'(beat_cnt), 64'd0);
    chk("rst_drop_cnt", 64'(drop_cnt), 64'd0);
    @(posedge clk); #1;
    sclr = 1'b0;
    @(negedge clk);
    chk("idle_res_ready", 64'(res_ready), 64'd1);
    @(posedge clk); #1;

    // All four lanes, sign extension on each.
    push(64'hFFFF_FFFF_FFFF_FFF0, 2'd0, 1'b0);
    push(64'hFFFF_FFFF_FFFF_FF81, 2'd1, 1'b0);
    push(64'h0000_0000_0000_7FFF, 2'd2, 1'b0);
    push(64'hFFFF_FFFF_8000_0001, 2'd3, 1'b1);
    send_word(64'h8000_0001_7FFF_81F0, 4'b1111, 1'b0);
    wait_drain();
    chk("beat_cnt_4", 64'(beat_cnt), 64'd4);

    // Chained word: one full-width beat.
    push(64'h0123_4567_89AB_CDEF, 2'd3, 1'b1);
    send_word(64'h0123_4567_89AB_CDEF, 4'b1111, 1'b1);
    wait_drain();
    chk("beat_cnt_5", 64'(beat_cnt), 64'd5);

    // Empty masks are dropped.
    for (int i = 0; i < 3; i++) begin
      send_word(64'h1234_5678_9ABC_DEF0 + 64'(i), 4'b0000, 1'b0);
      @(negedge clk);
      chk("drop_res_ready", 64'(res_ready), 64'd1);
      chk("drop_out_valid", 64'(out_valid), 64'd0);
      @(posedge clk); #1;
    end
    chk("drop_cnt_3", 64'(drop_cnt), 64'd3);

    // Sparse mask with downstream stalls.
    push(64'hFFFF_FFFF_FFFF_FFA5, 2'd0, 1'b0);
    push(64'h0000_0000_0000_3333, 2'd2, 1'b1);
    send_word(64'h1111_2222_3333_44A5, 4'b0101, 1'b0);
    @(negedge clk);
    chk("tgl1_out_valid", 64'(out_valid), 64'd1);
    chk("tgl1_res_ready", 64'(res_ready), 64'd0);
    @(posedge clk); #1; out_ready = 1'b0;
    @(negedge clk);
    chk("tgl2_out_valid", 64'(out_valid), 64'd1);
    chk("tgl2_res_ready", 64'(res_ready), 64'd0);
    @(posedge clk); #1; out_ready = 1'b1;
    @(negedge clk);
    chk("tgl3_res_ready", 64'(res_ready), 64'd1);
    chk("tgl3_out_last", 64'(out_last), 64'd1);
    @(posedge clk); #1; out_ready = 1'b0;
    @(negedge clk);
    chk("tgl4_out_valid", 64'(out_valid), 64'd0);
    @(posedge clk); #1; out_ready = 1'b1;
    wait_drain();
    chk("beat_cnt_7", 64'(beat_cnt), 64'd7);

    // Back-to-back words with no bubble.
    push(64'hFFFF_FFFF_FFFF_FF99, 2'd1, 1'b1);
    push(64'h0000_0000_7000_0000, 2'd3, 1'b1);
    send_word(64'h0000_0000_0000_9900, 4'b0010, 1'b0);
    res_valid = 1'b1; res_data = 64'h7000_0000_0000_0000;
    select_precision = 4'b1000; active_chain = 1'b0;
    @(negedge clk);
    chk("b2b_res_ready", 64'(res_ready), 64'd1);
    chk("b2b_first_valid", 64'(out_valid), 64'd1);
    @(posedge clk); #1;
    res_valid = 1'b0;
    @(negedge clk);
    chk("b2b_second_valid", 64'(out_valid), 64'd1);
    chk("b2b_second_lane", 64'(out_lane), 64'd3);
    @(posedge clk); #1;
    wait_drain();
    chk("beat_cnt_9", 64'(beat_cnt), 64'd9);

    // Reset during the second beat of a four-lane word.
    push(64'h0000_0000_0000_0004, 2'd0, 1'b0);
    send_word(64'h4000_1234_0102_0304, 4'b1111, 1'b0);
    @(posedge clk); #1;
    sclr = 1'b1;
    @(negedge clk);
    chk("sclr_out_valid", 64'(out_valid), 64'd0);
    chk("sclr_beat_cnt", 64'(beat_cnt), 64'd0);
    chk("sclr_drop_cnt", 64'(drop_cnt), 64'd0);
    chk("sclr_res_ready", 64'(res_ready), 64'd0);
    @(posedge clk); #1;
    sclr = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("post_sclr_idle", 64'(out_valid), 64'd0);
    end
    @(posedge clk); #1;
    push(64'h0000_0000_0000_0005, 2'd0, 1'b1);
    send_word(64'h0000_0000_0000_0005, 4'b0001, 1'b0);
    wait_drain();
    chk("beat_cnt_after_sclr", 64'(beat_cnt), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
